// File: rtl/reg_load_sequencer_pkg.sv
// Shared command/FunSel codes, FSM encoding and byte-timeout constant for
// the register load sequencer.
package reg_load_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_DEC    = 3'b000,
    OP_INC    = 3'b001,
    OP_RSVD   = 3'b010,
    OP_CLR    = 3'b011,
    OP_LOAD8Z = 3'b100,
    OP_LOAD16 = 3'b101,
    OP_LOAD8H = 3'b110,
    OP_LOAD8S = 3'b111
  } cmd_op_e;

  // Register FunSel codes; these match the opcodes except LOAD16.
  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD16 = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LOAD8Z = 3'b100;
  localparam logic [2:0] FS_LOAD8H = 3'b110;
  localparam logic [2:0] FS_LOAD8S = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_LO = 3'd1,
    S_GET_HI = 3'd2,
    S_ISSUE  = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic [7:0] BYTE_TIMEOUT = 8'd255;

  // Map a command opcode onto the FunSel code the Registers expect.
  function automatic logic [2:0] funsel_of(input logic [2:0] op);
    logic [2:0] fs;
    case (op)
      OP_DEC:    fs = FS_DEC;
      OP_INC:    fs = FS_INC;
      OP_CLR:    fs = FS_CLR;
      OP_LOAD8Z: fs = FS_LOAD8Z;
      OP_LOAD16: fs = FS_LOAD16;
      OP_LOAD8H: fs = FS_LOAD8H;
      OP_LOAD8S: fs = FS_LOAD8S;
      default:   fs = FS_DEC;
    endcase
    return fs;
  endfunction

  // One-hot select of one of four Registers.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/reg_load_sequencer_timer.sv
// Byte wait timer: counts cycles spent waiting for a memory byte and flags
// when the timeout value is reached. Clear has priority over counting.
module reg_byte_timer
  import reg_load_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  logic [7:0] r_count;

  // Wait counter; holds at the timeout value rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_count_en && (r_count != BYTE_TIMEOUT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == BYTE_TIMEOUT);

endmodule

// File: rtl/reg_load_sequencer.sv
// Sequencer that accepts register commands, gathers load bytes from memory
// and issues a single-cycle operation to one of four Registers. Moore FSM.
module reg_load_sequencer
  import reg_load_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [1:0]  CmdDest,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [15:0] RegI,
  output logic [2:0]  RegFunSel,
  output logic [3:0]  RegE,
  output logic        Done,
  output logic        Err
);

  state_e      r_state;
  state_e      w_next;
  logic [2:0]  r_op;
  logic [1:0]  r_dest;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [15:0] r_last_i;
  logic [2:0]  r_last_funsel;

  logic        w_waiting;
  logic        w_cmd_acc;
  logic        w_byte_acc;
  logic        w_issue;
  logic        w_expired;
  logic [15:0] w_issue_i;
  logic [2:0]  w_issue_funsel;

  assign w_waiting  = (r_state == S_GET_LO) || (r_state == S_GET_HI);
  assign w_cmd_acc  = (r_state == S_IDLE) && CmdValid;
  assign w_byte_acc = w_waiting && ByteValid;
  assign w_issue    = (r_state == S_ISSUE);

  // The timer sits at zero whenever nothing is awaited, so it starts from
  // zero on every entry to a byte-wait state and restarts on each byte.
  reg_byte_timer u_timer (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_clear    (!w_waiting || w_byte_acc),
    .i_count_en (w_waiting && !ByteValid),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; a byte in the expiry cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (CmdValid) begin
          case (CmdOp)
            OP_DEC, OP_INC, OP_CLR:                      w_next = S_ISSUE;
            OP_LOAD8Z, OP_LOAD16, OP_LOAD8H, OP_LOAD8S:  w_next = S_GET_LO;
            default:                                     w_next = S_ERR;
          endcase
        end
      end
      S_GET_LO: begin
        if (ByteValid)      w_next = (r_op == OP_LOAD16) ? S_GET_HI : S_ISSUE;
        else if (w_expired) w_next = S_ERR;
      end
      S_GET_HI: begin
        if (ByteValid)      w_next = S_ISSUE;
        else if (w_expired) w_next = S_ERR;
      end
      S_ISSUE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command and byte capture; bytes are zeroed on each new command so a
  // stale or aborted load never leaks into a later RegI value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_op   <= OP_DEC;
      r_dest <= 2'd0;
      r_lo   <= 8'h00;
      r_hi   <= 8'h00;
    end else begin
      if (w_cmd_acc) begin
        r_op   <= CmdOp;
        r_dest <= CmdDest;
        r_lo   <= 8'h00;
        r_hi   <= 8'h00;
      end
      if (w_byte_acc && (r_state == S_GET_LO)) r_lo <= ByteIn;
      if (w_byte_acc && (r_state == S_GET_HI)) r_hi <= ByteIn;
    end
  end

  assign w_issue_funsel = funsel_of(r_op);
  assign w_issue_i      = (r_op == OP_LOAD16) ? {r_hi, r_lo} : {8'h00, r_lo};

  // Remember the last issued bus values so RegI/RegFunSel hold between ops.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_last_i      <= 16'h0000;
      r_last_funsel <= 3'b000;
    end else if (w_issue) begin
      r_last_i      <= w_issue_i;
      r_last_funsel <= w_issue_funsel;
    end
  end

  assign RegI      = w_issue ? w_issue_i      : r_last_i;
  assign RegFunSel = w_issue ? w_issue_funsel : r_last_funsel;
  assign RegE      = w_issue ? onehot4(r_dest) : 4'b0000;
  assign Done      = w_issue;
  assign Err       = (r_state == S_ERR);
  assign ByteReady = w_waiting;
  assign CmdReady  = (r_state == S_IDLE) && !Reset;

endmodule
